// File: rtl/ysyx_22050854_mdu.sv
// ysyx_22050854_mdu: iterative RV64M multiply/divide unit with a valid/ready handshake.
// Define YSYX_22050854_MDU_FASTMUL_EN for a single-cycle multiply (division stays iterative).
module ysyx_22050854_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      mulctr,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic          ms, w, lo, rem, sa, sb, dz;
    logic [6:0]    cnt, n_init;
    logic [63:0]   a;
    logic [127:0]  p, mul_next, div_next, full;
    logic          is_mul, is_div, i_w, sg1, sg2, s1, s2;
    logic [63:0]   x1, x2, m1, m2, qv, rv, dv, v64, res_n;
    logic [31:0]   lo32;
    logic [64:0]   rsh;
    logic [63:0]   rdiff;
    logic          ge;
    assign is_mul = mulctr == 4'b1001 || mulctr == 4'b1000 || (mulctr[3:2] == 2'b00 && mulctr[1:0] != 2'b00);
    assign is_div = mulctr[2];
    assign i_w    = mulctr == 4'b1000 || mulctr[3:2] == 2'b11;
    assign sg1    = is_mul ? (mulctr == 4'b0001 || mulctr == 4'b0010) : !mulctr[0];
    assign sg2    = is_mul ? mulctr == 4'b0001 : !mulctr[0];
    assign x1     = i_w ? {{32{sg1 & src1[31]}}, src1[31:0]} : src1;
    assign x2     = i_w ? {{32{sg2 & src2[31]}}, src2[31:0]} : src2;
    assign s1     = sg1 & x1[63];
    assign s2     = sg2 & x2[63];
    assign m1     = s1 ? -x1 : x1;
    assign m2     = s2 ? -x2 : x2;
    // Restoring divide step: p holds {remainder, dividend/quotient}
    assign rsh      = p[127:63];
    assign ge       = rsh >= {1'b0, a};
    assign rdiff    = rsh[63:0] - a;
    assign div_next = {ge ? rdiff : rsh[63:0], p[62:0], ge};
`ifdef YSYX_22050854_MDU_FASTMUL_EN
    logic [127:0] fprod;
    assign fprod    = {64'b0, a} * {64'b0, p[63:0]};
    // W product lands in p[63:32] to match the iterative layout
    assign mul_next = w ? {fprod[95:0], 32'b0} : fprod;
    assign n_init   = is_mul ? 7'd1 : i_w ? 7'd32 : 7'd64;
`else
    logic [64:0] msum;
    assign msum     = {1'b0, p[127:64]} + {1'b0, p[0] ? a : 64'b0};
    assign mul_next = {msum, p[63:1]};
    assign n_init   = i_w ? 7'd32 : 7'd64;
`endif
    assign full  = (sa ^ sb) ? -p : p;
    // Divide-by-zero quotient is all ones; the remainder already equals the dividend
    assign qv    = dz ? {64{1'b1}} : (sa ^ sb) ? -p[63:0] : p[63:0];
    assign rv    = sa ? -p[127:64] : p[127:64];
    assign dv    = rem ? rv : qv;
    assign lo32  = ms ? full[63:32] : dv[31:0];
    assign v64   = ms ? (lo ? full[63:0] : full[127:64]) : dv;
    assign res_n = w ? {{32{lo32[31]}}, lo32} : v64;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            a         <= '0;
            p         <= '0;
            {ms, w, lo, rem, sa, sb, dz} <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && (is_mul || is_div)) begin
                    state    <= CALC;
                    in_ready <= 1'b0;
                    ms       <= is_mul;
                    w        <= i_w;
                    lo       <= mulctr[3];
                    rem      <= mulctr[1];
                    sa       <= s1;
                    sb       <= s2;
                    dz       <= x2 == 64'b0;
                    a        <= is_mul ? m1 : m2;
                    p        <= {64'b0, is_mul ? m2 : (i_w ? {m1[31:0], 32'b0} : m1)};
                    cnt      <= n_init;
                end
                CALC: if (cnt != 7'd0) begin
                    p   <= ms ? mul_next : div_next;
                    cnt <= cnt - 7'd1;
                end else begin
                    result    <= res_n;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22050854_mdu.sv
// tb_ysyx_22050854_mdu: directed vectors, random ops against an arithmetic model, and handshake corner cases.
module tb_ysyx_22050854_mdu;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0]  mulctr = '0;
    logic [63:0] src1 = '0, src2 = '0;
    logic        in_ready, out_valid;
    logic [63:0] result;
    int tests = 0, fails = 0;
    typedef struct {logic [3:0] op; logic [63:0] a; logic [63:0] b; logic [63:0] exp;} vec_t;
    vec_t tv[$];
    logic [3:0] ops[13] = '{4'b1001, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                            4'b0111, 4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

    ysyx_22050854_mdu #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mulctr(mulctr), .src1(src1), .src2(src2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] pr;
        longint sa, sb;
        int x, y;
        logic [31:0] r32;
        sa = a; sb = b; x = a[31:0]; y = b[31:0];
        case (op)
            4'b1001: return a * b;
            4'b0001: begin pr = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return pr[127:64]; end
            4'b0010: begin pr = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); return pr[127:64]; end
            4'b0011: begin pr = {64'b0, a} * {64'b0, b}; return pr[127:64]; end
            4'b0100: if (b == 0) return '1; else if (a == 64'h8000_0000_0000_0000 && b == '1) return a; else return 64'(sa / sb);
            4'b0110: if (b == 0) return a; else if (a == 64'h8000_0000_0000_0000 && b == '1) return 0; else return 64'(sa % sb);
            4'b0101: if (b == 0) return '1; else return a / b;
            4'b0111: if (b == 0) return a; else return a % b;
            4'b1000: r32 = a[31:0] * b[31:0];
            4'b1100: if (y == 0) r32 = '1; else if (x == 32'h8000_0000 && y == -1) r32 = x; else r32 = x / y;
            4'b1110: if (y == 0) r32 = x; else if (x == 32'h8000_0000 && y == -1) r32 = 0; else r32 = x % y;
            4'b1101: if (y == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
            default: if (y == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        endcase
        return {{32{r32[31]}}, r32};
    endfunction

    function automatic int lat(input logic [3:0] op);
        bit m, wop;
        m   = op == 4'b1001 || op == 4'b1000 || (op[3:2] == 2'b00 && op[1:0] != 2'b00);
        wop = op == 4'b1000 || op[3:2] == 2'b11;
`ifdef YSYX_22050854_MDU_FASTMUL_EN
        if (m) return 2;
`endif
        return wop ? 33 : 65;
    endfunction

    task automatic add(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp;
        tv.push_back(v);
    endtask

    task automatic start(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        mulctr = op; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        for (k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp);
        int k;
        start(op, a, b);
        chk({name, " busy"}, 64'(in_ready), 64'd0);
        wait_valid(k);
        chk({name, " latency"}, 64'(k), 64'(lat(op)));
        chk({name, " result"}, result, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " idle"}, {62'b0, in_ready, out_valid}, 64'b10);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return {$urandom, $urandom};
            1: return 64'd0;
            2: return '1;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'($urandom_range(0, 20)) - 64'd10;
            default: return {$urandom, 32'h8000_0000};
        endcase
    endfunction

    initial begin
        int k, seen;
        logic [3:0] op;
        logic [63:0] a, b;
        add(4'b1001, 64'd3, -64'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        add(4'b0011, '1, 64'd2, 64'd1);
        add(4'b0100, 64'd7, 64'd0, '1);
        add(4'b0110, 64'd7, 64'd0, 64'd7);
        add(4'b1101, 64'd5, 64'd0, '1);
        add(4'b0100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
        add(4'b0110, 64'h8000_0000_0000_0000, '1, 64'd0);
        add(4'b1100, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000);
        add(4'b0110, -64'd7, 64'd2, '1);
        add(4'b1111, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF);
        add(4'b0010, '1, 64'd2, '1);
        add(4'b0001, '1, '1, 64'd0);
        add(4'b0101, 64'd100, 64'd7, 64'd14);
        add(4'b0111, 64'd100, 64'd7, 64'd2);
        add(4'b1000, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        add(4'b1110, 64'h0000_0000_FFFF_FFF9, 64'd2, '1);
        add(4'b0100, -64'd7, 64'd2, -64'd3);
        add(4'b1100, 64'h0000_0000_FFFF_FFF9, 64'd0, '1);
        add(4'b1110, 64'h1234_5678_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9);

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {in_ready, out_valid, result}, {1'b1, 1'b0, 64'd0});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset outputs", {in_ready, out_valid, result}, {1'b1, 1'b0, 64'd0});

        foreach (tv[i]) run_op($sformatf("vec%0d op%b", i, tv[i].op), tv[i].op, tv[i].a, tv[i].b, tv[i].exp);

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 12)];
            a = pick(); b = pick();
            run_op($sformatf("rand%0d op%b a=%h b=%h", i, op, a, b), op, a, b, model(op, a, b));
        end

        // No-op codes are swallowed without leaving IDLE
        start(4'b0000, 64'd1, 64'd1);
        chk("nop0000 ready", 64'(in_ready), 64'd1);
        start(4'b1011, 64'd1, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("nop1011 no output", {62'b0, in_ready, out_valid}, 64'b10);

        // Backpressure: result held in DONE
        start(4'b0101, 64'd100, 64'd7);
        wait_valid(k);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d", i), {in_ready, out_valid, result}, {1'b0, 1'b1, 64'd14});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release idle", {62'b0, in_ready, out_valid}, 64'b10);
        run_op("after release mul", 4'b1001, 64'd3, -64'd5, 64'hFFFF_FFFF_FFFF_FFF1);

        // Flush during CALC
        start(4'b0100, 64'd1000, 64'd3);
        repeat (19) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush calc", {62'b0, in_ready, out_valid}, 64'b10);
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("flush no output", 64'(seen), 64'd0);

        // Flush and handshake together in DONE
        start(4'b1000, 64'd6, 64'd7);
        wait_valid(k);
        chk("pre-flush result", result, 64'd42);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        chk("flush done", {62'b0, in_ready, out_valid}, 64'b10);

        // Asynchronous reset mid-CALC
        start(4'b0110, -64'd7, 64'd2);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset", {in_ready, out_valid, result}, {1'b1, 1'b0, 64'd0});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after reset divu", 4'b0101, 64'd100, 64'd7, 64'd14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
